lcd_timing_gen: RTL

Generates the 480x272 parallel-RGB LCD raster: HSYNC/VSYNC/DE timing plus a built-in RGB565 test pattern, all registered and mutually aligned. It sits directly downstream of the PLL pixel clock (9 MHz) and drives the LCD pins (LCD_CLK is the same clock, routed outside this block). It is the timing/pattern source feeding the panel and the first stage any future framebuffer reader will hook into via `x`/`y`/`de`.

---
 rtl/lcd_timing_gen.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/lcd_timing_gen.sv
// 480x272 parallel-RGB LCD raster generator: HSYNC/VSYNC/DE timing, active x/y
// coordinates and a selectable RGB565 test pattern, all registered and aligned.
module lcd_timing_gen #(
  parameter int H_ACTIVE       = 480,
  parameter int H_FP           = 2,
  parameter int H_SYNC         = 41,
  parameter int H_BP           = 2,
  parameter int V_ACTIVE       = 272,
  parameter int V_FP           = 2,
  parameter int V_SYNC         = 10,
  parameter int V_BP           = 2,
  parameter int PATTERN_FRAMES = 120
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pat_auto,
  input  logic [1:0] pat_sel,
  output logic       lcd_hsync,
  output logic       lcd_vsync,
  output logic       lcd_de,
  output logic [4:0] lcd_r,
  output logic [5:0] lcd_g,
  output logic [4:0] lcd_b,
  output logic [9:0] x,
  output logic [8:0] y,
  output logic       frame_start
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int FC_W    = (PATTERN_FRAMES > 1) ? $clog2(PATTERN_FRAMES) : 1;

  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_SYNCW = 10'(H_SYNC);
  localparam logic [9:0] HA0     = 10'(H_SYNC + H_BP);
  localparam logic [9:0] HA1     = 10'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [9:0] BAR_W   = 10'(H_ACTIVE / 8);
  localparam logic [8:0] V_LAST  = 9'(V_TOTAL - 1);
  localparam logic [8:0] V_SYNCW = 9'(V_SYNC);
  localparam logic [8:0] VA0     = 9'(V_SYNC + V_BP);
  localparam logic [8:0] VA1     = 9'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(PATTERN_FRAMES - 1);

  logic [9:0]      h_cnt_q, h_cnt_d;
  logic [8:0]      v_cnt_q, v_cnt_d;
  logic [FC_W-1:0] frame_cnt_q, frame_cnt_d;
  logic            run_q, run_d;
  logic [1:0]      pat_q, pat_d;

  logic            hsync_q, hsync_d;
  logic            vsync_q, vsync_d;
  logic            de_q, de_d;
  logic [4:0]      r_q, r_d;
  logic [5:0]      g_q, g_d;
  logic [4:0]      b_q, b_d;
  logic [9:0]      x_q, x_d;
  logic [8:0]      y_q, y_d;
  logic            fs_q, fs_d;

  logic            h_wrap;
  logic            frame_edge;
  logic            h_act, v_act;
  logic [9:0]      x_act;
  logic [8:0]      y_act;
  logic [9:0]      bar;

  // Raster counters and the per-frame pattern register. The frame that begins
  // on entering auto mode (or after reset) is frame 0 of the current pattern.
  always_comb begin
    h_wrap      = (h_cnt_q == H_LAST);
    frame_edge  = (h_cnt_q == 10'd0) && (v_cnt_q == 9'd0);
    h_cnt_d     = h_wrap ? 10'd0 : h_cnt_q + 10'd1;
    v_cnt_d     = v_cnt_q;
    frame_cnt_d = frame_cnt_q;
    run_d       = run_q;
    pat_d       = pat_q;

    if (h_wrap) begin
      v_cnt_d = (v_cnt_q == V_LAST) ? 9'd0 : v_cnt_q + 9'd1;
    end

    if (!pat_auto) begin
      frame_cnt_d = '0;
      run_d       = 1'b0;
      if (frame_edge) begin
        pat_d = pat_sel;
      end
    end else if (frame_edge) begin
      if (!run_q) begin
        run_d       = 1'b1;
        frame_cnt_d = '0;
      end else if (frame_cnt_q == FC_LAST) begin
        frame_cnt_d = '0;
        pat_d       = pat_q + 2'd1;
      end else begin
        frame_cnt_d = frame_cnt_q + FC_W'(1);
      end
    end
  end

  // Decode the current counter state into next pin values; the pattern is
  // driven by pat_q, which only ever changes on a cycle where de is low.
  always_comb begin
    h_act   = (h_cnt_q >= HA0) && (h_cnt_q < HA1);
    v_act   = (v_cnt_q >= VA0) && (v_cnt_q < VA1);
    x_act   = h_cnt_q - HA0;
    y_act   = v_cnt_q - VA0;
    bar     = x_act / BAR_W;

    hsync_d = (h_cnt_q >= H_SYNCW);
    vsync_d = (v_cnt_q >= V_SYNCW);
    de_d    = h_act && v_act;
    x_d     = de_d ? x_act : 10'd0;
    y_d     = v_act ? y_act : 9'd0;
    fs_d    = frame_edge;
    r_d     = 5'd0;
    g_d     = 6'd0;
    b_d     = 5'd0;

    if (de_d) begin
      case (pat_q)
        2'd0: begin
          if (bar < 10'd8) begin
            r_d = {5{~bar[1]}};
            g_d = {6{~bar[2]}};
            b_d = {5{~bar[0]}};
          end
        end
        2'd1: begin
          r_d = x_act[8:4];
          g_d = x_act[8:3];
          b_d = x_act[8:4];
        end
        2'd2: begin
          if (x_act[4] ^ y_act[4]) begin
            r_d = 5'd31;
            g_d = 6'd63;
            b_d = 5'd31;
          end
        end
        default: begin
          r_d = 5'd31;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt_q     <= 10'd0;
      v_cnt_q     <= 9'd0;
      frame_cnt_q <= '0;
      run_q       <= 1'b0;
      pat_q       <= 2'd0;
      hsync_q     <= 1'b1;
      vsync_q     <= 1'b1;
      de_q        <= 1'b0;
      r_q         <= 5'd0;
      g_q         <= 6'd0;
      b_q         <= 5'd0;
      x_q         <= 10'd0;
      y_q         <= 9'd0;
      fs_q        <= 1'b0;
    end else begin
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      run_q       <= run_d;
      pat_q       <= pat_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      de_q        <= de_d;
      r_q         <= r_d;
      g_q         <= g_d;
      b_q         <= b_d;
      x_q         <= x_d;
      y_q         <= y_d;
      fs_q        <= fs_d;
    end
  end

  assign lcd_hsync   = hsync_q;
  assign lcd_vsync   = vsync_q;
  assign lcd_de      = de_q;
  assign lcd_r       = r_q;
  assign lcd_g       = g_q;
  assign lcd_b       = b_q;
  assign x           = x_q;
  assign y           = y_q;
  assign frame_start = fs_q;

endmodule
